// File: rtl/pad_frame_writer.sv
// Loads a raw IMG_W x IMG_ROWS grayscale frame into a zero-bordered frame memory with a sync read port.
// Define FRAME_CNT_EN to add a 16-bit completed-frame counter output (frame_count).
module pad_frame_writer #(
    parameter int IMG_W    = 256,
    parameter int IMG_ROWS = 32,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_pixel,
    output logic              busy,
    output logic              frame_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]       frame_count
`endif
);

    localparam int PAD_W     = IMG_W + 2;
    localparam int COL_W     = $clog2(PAD_W);
    localparam int ROW_W     = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(PAD_W - 1);
    localparam logic [COL_W-1:0] COL_DATA_LAST = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_LEFT,
        S_DATA,
        S_RIGHT,
        S_BOTTOM,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          rd_data_q;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic [7:0]          mem [MEM_DEPTH];
`ifdef FRAME_CNT_EN
    logic [15:0]         frame_count_q, frame_count_d;
`endif

    // Every padded location is written exactly once in linear order; only DATA may stall.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        col_d        = col_q;
        row_d        = row_q;
        busy_d       = busy_q;
        in_ready_d   = 1'b0;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_TOP;
                    wr_addr_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                    busy_d    = 1'b1;
                end
            end
            S_TOP: begin
                wr_en = 1'b1;
                col_d = col_q + COL_W'(1);
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = S_LEFT;
                end
            end
            S_LEFT: begin
                wr_en      = 1'b1;
                col_d      = COL_W'(1);
                state_d    = S_DATA;
                in_ready_d = 1'b1;
            end
            S_DATA: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    wr_en   = 1'b1;
                    wr_data = in_pixel;
                    col_d   = col_q + COL_W'(1);
                    if (col_q == COL_DATA_LAST) begin
                        state_d    = S_RIGHT;
                        in_ready_d = 1'b0;
                    end
                end
            end
            S_RIGHT: begin
                wr_en = 1'b1;
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    state_d = S_BOTTOM;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = S_LEFT;
                end
            end
            S_BOTTOM: begin
                wr_en = 1'b1;
                col_d = col_q + COL_W'(1);
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                frame_done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (wr_en) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
    end

`ifdef FRAME_CNT_EN
    always_comb begin
        frame_count_d = frame_count_q;
        if (state_q == S_DONE) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_addr_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef FRAME_CNT_EN
            frame_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            col_q         <= col_d;
            row_q         <= row_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
            frame_done_q  <= frame_done_d;
`ifdef FRAME_CNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    // Frame memory is deliberately not reset; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign rd_data    = rd_data_q;
`ifdef FRAME_CNT_EN
    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_pad_frame_writer.sv
// Self-checking bench for pad_frame_writer: linear-write-index reference model, read-back tables,
// abort-by-reset, gap, restart-while-busy and read/write collision scenarios.
module tb_pad_frame_writer;

    localparam int IMG_W            = 256;
    localparam int IMG_ROWS         = 32;
    localparam int ADDR_W           = 14;
    localparam int PAD_W            = IMG_W + 2;
    localparam int FRAME_WORDS      = PAD_W * (IMG_ROWS + 2);
    localparam int MIN_FRAME_CYCLES = FRAME_WORDS + 1;
    localparam int N_RD_VECS        = 12;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        exp_data;
    } rd_vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_pixel;
    logic              in_ready;
    logic              busy;
    logic              frame_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
`ifdef FRAME_CNT_EN
    logic [15:0]       frame_count;
`endif

    int      checks     = 0;
    int      failures   = 0;
    int      exp_frames = 0;
    logic [7:0] exp_mem [FRAME_WORDS];
    rd_vec_t rd_vecs [N_RD_VECS];

    always #5 clk = ~clk;

    pad_frame_writer #(
        .IMG_W   (IMG_W),
        .IMG_ROWS(IMG_ROWS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .busy       (busy),
        .frame_done (frame_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`ifdef FRAME_CNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // A write index is an active pixel when it lies inside the one-pixel zero border.
    function automatic bit is_active(input int w);
        int r;
        int c;
        r = w / PAD_W;
        c = w % PAD_W;
        return (r >= 1) && (r <= IMG_ROWS) && (c >= 1) && (c <= IMG_W);
    endfunction

    task automatic build_image(input bit random_pix);
        int r;
        int c;
        for (int w = 0; w < FRAME_WORDS; w++) begin
            r = w / PAD_W - 1;
            c = w % PAD_W - 1;
            if (!is_active(w)) exp_mem[w] = 8'h00;
            else if (random_pix) exp_mem[w] = 8'($urandom);
            else exp_mem[w] = 8'((r + c) & 255);
        end
    endtask

    task automatic checkFrameCount(input string name);
`ifdef FRAME_CNT_EN
        checkOutput(name, 32'(frame_count), 32'(exp_frames));
`else
        checks = checks + 0;
        if (name.len() < 0) $display("[TB] %s", name);
`endif
    endtask

    // Drives one frame; the model tracks the linear write index, which advances every
    // cycle except on an active location with in_valid low.
    task automatic applyStimulus(input int gap_pct, input int restart_at, input int reset_at,
                                 input int coll_addr, input logic [7:0] coll_old, input string tag);
        int w, cyc, stalls, trace_err, done_cyc, coll_phase, seen;
        bit exp_ready, exp_busy, exp_done;
        w = 0; cyc = 0; stalls = 0; trace_err = 0; done_cyc = -1; coll_phase = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc <= 3 * MIN_FRAME_CYCLES) begin
            if (cyc == reset_at) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                #1;
                checkOutput({tag, "_rst_in_ready"}, 32'(in_ready), 32'd0);
                checkOutput({tag, "_rst_busy"}, 32'(busy), 32'd0);
                checkOutput({tag, "_rst_frame_done"}, 32'(frame_done), 32'd0);
                checkOutput({tag, "_rst_rd_data"}, 32'(rd_data), 32'd0);
                exp_frames = 0;
                checkFrameCount({tag, "_rst_frame_count"});
                checkOutput({tag, "_trace_errors"}, 32'(trace_err), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                seen  = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (frame_done !== 1'b0 || busy !== 1'b0) seen++;
                end
                checkOutput({tag, "_no_done_after_reset"}, 32'(seen), 32'd0);
                return;
            end
            exp_ready = (w < FRAME_WORDS) && is_active(w);
            exp_busy  = (w <= FRAME_WORDS);
            exp_done  = (w == FRAME_WORDS + 1);
            if (in_ready !== exp_ready || busy !== exp_busy || frame_done !== exp_done) trace_err++;
            if (frame_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (coll_phase == 2) begin
                checkOutput({tag, "_collision_new"}, 32'(rd_data), 32'(exp_mem[coll_addr]));
                coll_phase = 3;
                rd_addr    = '0;
            end
            if (coll_phase == 1) begin
                checkOutput({tag, "_collision_old"}, 32'(rd_data), 32'(coll_old));
                coll_phase = 2;
            end
            if (w == FRAME_WORDS + 1) break;
            if (coll_phase == 0 && w == coll_addr) begin
                rd_addr    = ADDR_W'(coll_addr);
                coll_phase = 1;
            end
            start    = (cyc == restart_at);
            in_valid = ($urandom_range(99) >= 32'(gap_pct)) || (w == coll_addr);
            in_pixel = exp_ready ? exp_mem[w] : 8'hAA;
            if (exp_ready && !in_valid) stalls++;
            @(negedge clk);
            cyc++;
            if (w >= FRAME_WORDS || !exp_ready || in_valid) w++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'(MIN_FRAME_CYCLES + stalls));
        checkOutput({tag, "_trace_errors"}, 32'(trace_err), 32'd0);
        if (coll_addr >= 0) checkOutput({tag, "_collision_seen"}, 32'(coll_phase), 32'd3);
        exp_frames++;
        checkFrameCount({tag, "_frame_count"});
    endtask

    task automatic verify_image(input string tag);
        int bad;
        int first_addr;
        logic [7:0] first_got;
        bad = 0; first_addr = -1; first_got = 8'h00;
        for (int a = 0; a < FRAME_WORDS; a++) begin
            rd_addr = ADDR_W'(a);
            @(negedge clk);
            if (rd_data !== exp_mem[a]) begin
                if (bad == 0) begin
                    first_addr = a;
                    first_got  = rd_data;
                end
                bad++;
            end
        end
        rd_addr = '0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL %s_image: %0d bad words, first addr %0d got 0x%0h expected 0x%0h",
                     tag, bad, first_addr, first_got, exp_mem[first_addr]);
        end
    endtask

    task automatic applyReadTable(input string tag);
        for (int i = 0; i < N_RD_VECS; i++) begin
            rd_addr = rd_vecs[i].addr;
            @(negedge clk);
            checkOutput($sformatf("%s_rd[%0d]@%0d", tag, i, rd_vecs[i].addr),
                        32'(rd_data), 32'(rd_vecs[i].exp_data));
        end
        rd_addr = '0;
    endtask

    task automatic idleCheck(input string tag);
        int ready_seen;
        int other_seen;
        ready_seen = 0; other_seen = 0;
        in_valid = 1'b1;
        in_pixel = 8'hAA;
        repeat (100) begin
            @(negedge clk);
            if (in_ready !== 1'b0) ready_seen++;
            if (busy !== 1'b0 || frame_done !== 1'b0) other_seen++;
        end
        in_valid = 1'b0;
        checkOutput({tag, "_idle_in_ready"}, 32'(ready_seen), 32'd0);
        checkOutput({tag, "_idle_busy_done"}, 32'(other_seen), 32'd0);
    endtask

    initial begin
        // Expected read-back of the (row+col)&0xFF pattern frame.
        rd_vecs[0]  = '{addr: ADDR_W'(0),    exp_data: 8'h00};
        rd_vecs[1]  = '{addr: ADDR_W'(257),  exp_data: 8'h00};
        rd_vecs[2]  = '{addr: ADDR_W'(258),  exp_data: 8'h00};
        rd_vecs[3]  = '{addr: ADDR_W'(8771), exp_data: 8'h00};
        rd_vecs[4]  = '{addr: ADDR_W'(259),  exp_data: 8'h00};
        rd_vecs[5]  = '{addr: ADDR_W'(260),  exp_data: 8'h01};
        rd_vecs[6]  = '{addr: ADDR_W'(515),  exp_data: 8'h00};
        rd_vecs[7]  = '{addr: ADDR_W'(516),  exp_data: 8'h00};
        rd_vecs[8]  = '{addr: ADDR_W'(517),  exp_data: 8'h01};
        rd_vecs[9]  = '{addr: ADDR_W'(4515), exp_data: 8'h90};
        rd_vecs[10] = '{addr: ADDR_W'(8512), exp_data: 8'h1E};
        rd_vecs[11] = '{addr: ADDR_W'(8513), exp_data: 8'h00};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'h00;
        rd_addr  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        checkFrameCount("reset_frame_count");
        rst_n = 1'b1;

        idleCheck("boot");

        $display("[TB] frame aborted by reset at cycle 5000");
        build_image(1'b0);
        applyStimulus(0, -1, 5000, -1, 8'h00, "abort");

        $display("[TB] pattern frame, start re-pulsed at cycle 1000");
        build_image(1'b0);
        applyStimulus(0, 1000, -1, -1, 8'h00, "pattern");
        verify_image("pattern");
        applyReadTable("pattern");
        idleCheck("post");
        applyReadTable("post_idle");

        $display("[TB] random frame with 30%% input gaps and collision at 260");
        build_image(1'b1);
        exp_mem[260] = 8'hC3;
        applyStimulus(30, -1, -1, 260, 8'h01, "gappy");
        verify_image("gappy");

        $display("[TB] random frame, gap-free");
        build_image(1'b1);
        applyStimulus(0, -1, -1, -1, 8'h00, "random");
        verify_image("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
